// File: rtl/pipelined_segmented_adder.sv
// ---------------------------------------------------------------------------
// pipelined_segmented_adder
//
// Pipelined, segmented ripple-carry adder/subtractor. The WIDTH-bit operands
// are cut into NSEG = WIDTH/SEG_WIDTH segments; segment k is added in stage k
// and its carry is registered into stage k+1. Not-yet-added upper segments of
// A and B' ride along in input-skew registers, finished lower segments ride
// along in output-deskew registers, so every bit of one result leaves the
// last stage on the same clock.
//
// Effective operation:  B' = sub_i ? ~b_i : b_i,  c0 = sub_i ? 1 : cin_i,
//                       result = A + B' + c0 (mod 2^WIDTH).
// Latency is NSEG cycles from the accepting edge; throughput is one per clock.
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   rst_i        synchronous active-high reset, flushes every stage
//   in_valid_i   operands/mode/carry-in valid
//   in_ready_o   block accepts a transaction this cycle
//   a_i, b_i     WIDTH-bit operands
//   cin_i        carry-in (add mode only)
//   sub_i        0: A+B+cin_i   1: A-B
//   out_valid_o  result valid
//   out_ready_i  downstream accepts the result
//   s_o          WIDTH-bit sum/difference
//   cout_o       carry out of the MSB (sub mode: 1 = no borrow, A >= B)
//   ovf_o        two's-complement signed overflow
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The source holds its payload steady while valid=1 and ready=0;
// the sink may not rely on payload while valid=0. in_ready_o depends
// combinationally only on out_ready_i (and rst_i); out_valid_o and all
// result bits come straight from flops.
//
// WIDTH must be a multiple of SEG_WIDTH and SEG_WIDTH must be >= 1.
// ---------------------------------------------------------------------------
module pipelined_segmented_adder #(
  parameter int WIDTH     = 64,
  parameter int SEG_WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int SW   = SEG_WIDTH;
  localparam int NSEG = WIDTH / SEG_WIDTH;

  // Whole-pipeline enable: everything advances together, or everything
  // (bubbles included) holds while a finished result waits for its sink.
  logic en;

  assign en = ~out_valid_o | out_ready_i;

  // Ready is forced high during reset: the pipeline is being emptied, and
  // anything offered in that window is discarded with the flush.
  assign in_ready_o = en | rst_i;

  for (genvar k = 0; k < NSEG; k++) begin : stg
    // Bits of A/B' that have not been added yet when entering stage k.
    localparam int REM = WIDTH - k * SW;

    logic [REM-1:0]      a_in;
    logic [REM-1:0]      b_in;
    logic                c_in;
    logic                v_in;
    logic [SW:0]         seg_sum;
    logic [(k+1)*SW-1:0] s_d;

    logic                v_q;
    logic                c_q;
    logic [(k+1)*SW-1:0] s_q;

    if (k == 0) begin : g_src
      // Stage 0 sees the raw request; subtraction is A + ~B + 1, so the
      // caller's carry-in is overridden in sub mode.
      assign a_in = a_i;
      assign b_in = sub_i ? ~b_i : b_i;
      assign c_in = sub_i | cin_i;
      assign v_in = in_valid_i;
    end else begin : g_src
      assign a_in = stg[k-1].g_skew.a_q;
      assign b_in = stg[k-1].g_skew.b_q;
      assign c_in = stg[k-1].c_q;
      assign v_in = stg[k-1].v_q;
    end

    // The lowest remaining segment is the one this stage owns.
    assign seg_sum = {1'b0, a_in[SW-1:0]} + {1'b0, b_in[SW-1:0]} + {{SW{1'b0}}, c_in};

    if (k == 0) begin : g_deskew
      assign s_d = seg_sum[SW-1:0];
    end else begin : g_deskew
      assign s_d = {seg_sum[SW-1:0], stg[k-1].s_q};
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (en) begin
        v_q <= v_in;
        c_q <= seg_sum[SW];
        s_q <= s_d;
      end
    end

    if (k < NSEG - 1) begin : g_skew
      // Upper segments still waiting for their stage.
      logic [REM-SW-1:0] a_q;
      logic [REM-SW-1:0] b_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_in[REM-1:SW];
          b_q <= b_in[REM-1:SW];
        end
      end
    end

    if (k == NSEG - 1) begin : g_last
      // Carry into the MSB is recovered from the MSB's own sum bit:
      // sum = a ^ b ^ cin  =>  cin = a ^ b ^ sum.
      logic c_msb;
      logic ovf_q;

      assign c_msb = a_in[SW-1] ^ b_in[SW-1] ^ seg_sum[SW-1];

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= c_msb ^ seg_sum[SW];
        end
      end
    end
  end

  assign out_valid_o = stg[NSEG-1].v_q;
  assign s_o         = stg[NSEG-1].s_q;
  assign cout_o      = stg[NSEG-1].c_q;
  assign ovf_o       = stg[NSEG-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_segmented_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_segmented_adder
//
// Three adders share one stimulus stream: SEG_WIDTH=16 (index 0, latency 4,
// the one that sees backpressure), SEG_WIDTH=64 (index 1, latency 1) and
// SEG_WIDTH=8 (index 2, latency 8). Indices 1 and 2 only see in_valid when
// index 0 accepts, so all three accept the same transactions.
// ---------------------------------------------------------------------------
module tb_pipelined_segmented_adder;

  localparam int W  = 64;
  localparam int EW = 32 + 32 + 1 + 1 + W;  // {accept cycle, stall count, ovf, cout, sum}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT wiring ----------------
  logic         in_valid;
  logic         in_valid_x;
  logic         out_ready_m;
  logic [W-1:0] a_d;
  logic [W-1:0] b_d;
  logic         cin_d;
  logic         sub_d;

  logic         ir_w [3];
  logic         ov_w [3];
  logic         or_w [3];
  logic         co_w [3];
  logic         of_w [3];
  logic [W-1:0] s_w  [3];

  assign in_valid_x = in_valid & ir_w[0];
  assign or_w[0]    = out_ready_m;
  assign or_w[1]    = 1'b1;
  assign or_w[2]    = 1'b1;

  pipelined_segmented_adder #(.WIDTH(W), .SEG_WIDTH(16)) u_dut16 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(ir_w[0]),
    .a_i(a_d), .b_i(b_d), .cin_i(cin_d), .sub_i(sub_d),
    .out_valid_o(ov_w[0]), .out_ready_i(or_w[0]),
    .s_o(s_w[0]), .cout_o(co_w[0]), .ovf_o(of_w[0])
  );

  pipelined_segmented_adder #(.WIDTH(W), .SEG_WIDTH(64)) u_dut64 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid_x), .in_ready_o(ir_w[1]),
    .a_i(a_d), .b_i(b_d), .cin_i(cin_d), .sub_i(sub_d),
    .out_valid_o(ov_w[1]), .out_ready_i(or_w[1]),
    .s_o(s_w[1]), .cout_o(co_w[1]), .ovf_o(of_w[1])
  );

  pipelined_segmented_adder #(.WIDTH(W), .SEG_WIDTH(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid_x), .in_ready_o(ir_w[2]),
    .a_i(a_d), .b_i(b_d), .cin_i(cin_d), .sub_i(sub_d),
    .out_valid_o(ov_w[2]), .out_ready_i(or_w[2]),
    .s_o(s_w[2]), .cout_o(co_w[2]), .ovf_o(of_w[2])
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];   // every accepted transaction, in order
  int            rd [3];     // per-DUT read pointer into exp_q
  int            stall_cnt = 0;
  int            n_vec     = 0;
  int            n_miss    = 0;

  // Expected result of the transaction currently being driven.
  logic [W-1:0]  exp_s;
  logic          exp_co;
  logic          exp_of;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
    logic         of;
  } vec_t;

  vec_t tbl [13];

  function automatic int lat_of(input int j);
    case (j)
      0:       return 4;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  // Reference arithmetic: wide add, overflow from operand/result signs.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mcin, input logic msub);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         ovf;
    bb   = msub ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, (msub | mcin)};
    ovf  = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
    return {ovf, full[W], full[W-1:0]};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor (runs forked from the main sequence) ----------------
  task automatic monitor();
    logic [EW-1:0] rec;
    int            lat;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int j = 0; j < 3; j++) rd[j] = exp_q.size();
      end else begin
        if (in_valid && ir_w[0])
          exp_q.push_back({cyc[31:0], stall_cnt[31:0], exp_of, exp_co, exp_s});
        for (int j = 0; j < 3; j++) begin
          if (ov_w[j] && or_w[j]) begin
            if (rd[j] >= exp_q.size()) begin
              chk($sformatf("dut%0d_unexpected_output", j), {{(W-1){1'b0}}, ov_w[j]}, '0);
            end else begin
              rec = exp_q[rd[j]];
              rd[j]++;
              lat = lat_of(j);
              if (j == 0) lat = lat + stall_cnt - int'(rec[W+33:W+2]);
              chk($sformatf("dut%0d_s", j),    s_w[j],              rec[W-1:0]);
              chk($sformatf("dut%0d_cout", j), {{(W-1){1'b0}}, co_w[j]}, {{(W-1){1'b0}}, rec[W]});
              chk($sformatf("dut%0d_ovf", j),  {{(W-1){1'b0}}, of_w[j]}, {{(W-1){1'b0}}, rec[W+1]});
              chk($sformatf("dut%0d_latency", j), W'(cyc - int'(rec[EW-1:W+34])), W'(lat));
            end
          end
        end
        if (ov_w[0] && !out_ready_m) stall_cnt++;
      end
    end
  endtask

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                      input logic tsub, input logic [W-1:0] es, input logic eco, input logic eof);
    logic ok;
    a_d = ta; b_d = tb; cin_d = tcin; sub_d = tsub;
    exp_s = es; exp_co = eco; exp_of = eof;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (ir_w[0]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_accept_timeout", {{(W-1){1'b0}}, ok}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                            input logic tcin, input logic tsub);
    logic [W+1:0] m;
    m = model(ta, tb, tcin, tsub);
    send(ta, tb, tcin, tsub, m[W-1:0], m[W], m[W+1]);
  endtask

  task automatic wait_drain(input string name);
    logic done;
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      done = 1'b1;
      for (int j = 0; j < 3; j++)
        if (ov_w[j] || rd[j] != exp_q.size()) done = 1'b0;
    end
    chk(name, {{(W-1){1'b0}}, done}, 64'd1);
    @(posedge clk); #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    tbl[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                 1'b0, 1'b0, 64'h0,                 1'b1, 1'b0};
    tbl[1]  = '{64'h0000_0000_0000_FFFF, 64'h1,                 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    tbl[2]  = '{64'h5,                   64'h7,                 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    tbl[3]  = '{64'h7,                   64'h5,                 1'b0, 1'b1, 64'h2,                 1'b1, 1'b0};
    tbl[4]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1,                 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    tbl[5]  = '{64'h8000_0000_0000_0000, 64'h1,                 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    tbl[6]  = '{64'h7,                   64'h5,                 1'b1, 1'b1, 64'h2,                 1'b1, 1'b0};
    tbl[7]  = '{64'h1,                   64'h2,                 1'b1, 1'b0, 64'h4,                 1'b0, 1'b0};
    tbl[8]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0,               1'b1, 1'b1};
    tbl[9]  = '{64'h0,                   64'h0,                 1'b0, 1'b1, 64'h0,                 1'b1, 1'b0};
    tbl[10] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                 1'b1, 1'b0, 64'h0,                 1'b1, 1'b0};
    tbl[11] = '{64'h00FF_00FF_00FF_00FF, 64'h0001_0001_0001_0001, 1'b0, 1'b0, 64'h0100_0100_0100_0100, 1'b0, 1'b0};
    tbl[12] = '{64'h0000_0000_0001_0000, 64'h1,                 1'b0, 1'b1, 64'h0000_0000_0000_FFFF, 1'b1, 1'b0};

    in_valid = 1'b0; out_ready_m = 1'b1;
    a_d = '0; b_d = '0; cin_d = 1'b0; sub_d = 1'b0;
    exp_s = '0; exp_co = 1'b0; exp_of = 1'b0;
    for (int j = 0; j < 3; j++) rd[j] = 0;

    fork
      monitor();
    join_none

    // Reset state (sampled while reset is still asserted).
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("rst_dut%0d_out_valid", j), {{(W-1){1'b0}}, ov_w[j]}, '0);
      chk($sformatf("rst_dut%0d_s", j),         s_w[j],                   '0);
      chk($sformatf("rst_dut%0d_cout", j),      {{(W-1){1'b0}}, co_w[j]}, '0);
      chk($sformatf("rst_dut%0d_ovf", j),       {{(W-1){1'b0}}, of_w[j]}, '0);
      chk($sformatf("rst_dut%0d_in_ready", j),  {{(W-1){1'b0}}, ir_w[j]}, 64'd1);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vectors, one at a time so each latency is uncontended.
    for (int i = 0; i < 13; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].s, tbl[i].co, tbl[i].of);
      wait_drain($sformatf("vec%0d_drain", i));
    end

    // Throughput: eight back-to-back transactions.
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] ai;
      ai = W'(i);
      send_model(ai, ai << 48, ai[0], 1'b0);
    end
    wait_drain("throughput_drain");

    // Backpressure: three in flight, sink stalls for three cycles.
    send_model(64'h1111_2222_3333_4444, 64'h0000_FFFF_0000_FFFF, 1'b1, 1'b0);
    send_model(64'h0123_4567_89AB_CDEF, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1);
    send_model(64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0, 1'b0);
    begin
      logic         seen;
      logic [W-1:0] hold;
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
        if (ov_w[0]) seen = 1'b1;
        else begin
          @(posedge clk); #1;
        end
      end
      chk("bp_first_valid", {{(W-1){1'b0}}, seen}, 64'd1);
      out_ready_m = 1'b0;
      hold = s_w[0];
      for (int t = 0; t < 3; t++) begin
        @(negedge clk);
        chk($sformatf("bp_in_ready_c%0d", t),  {{(W-1){1'b0}}, ir_w[0]}, '0);
        chk($sformatf("bp_out_valid_c%0d", t), {{(W-1){1'b0}}, ov_w[0]}, 64'd1);
        chk($sformatf("bp_s_stable_c%0d", t),  s_w[0], hold);
        @(posedge clk); #1;
      end
      out_ready_m = 1'b1;
    end
    wait_drain("bp_drain");

    // Reset mid-flight: two accepted, then one reset edge.
    send_model(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 1'b0);
    send_model(64'h0000_0000_0000_0042, 64'h0000_0000_0000_0002, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("midrst_dut%0d_out_valid", j), {{(W-1){1'b0}}, ov_w[j]}, '0);
      chk($sformatf("midrst_dut%0d_s", j),         s_w[j],                   '0);
    end
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      chk($sformatf("midrst_quiet_c%0d", t), {{(W-3){1'b0}}, ov_w[2], ov_w[1], ov_w[0]}, '0);
    end
    @(posedge clk); #1;
    send_model(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
    wait_drain("midrst_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pipelined_segmented_adder.md
Name: pipelined_segmented_adder

Overview:
- Parametrised, pipelined successor to the fixed 64-bit segmented ripple-carry adder.
- The WIDTH-bit operands are split into NSEG = WIDTH/SEG_WIDTH segments. Segment k is added in pipeline stage k; the carry is registered between stages.
- Adds add/subtract mode, signed-overflow flag and valid/ready handshake. Throughput is one operation per clock.
- Sits between the UART command decoder and the result serialiser.

Parameters:
- WIDTH, 64, operand and sum width in bits. Must be a multiple of SEG_WIDTH.
- SEG_WIDTH, 16, bits added per pipeline stage. Must be ≥1.

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- in_valid_i  input  1  operands/mode/carry-in valid
- in_ready_o  output  1  block accepts a transaction this cycle
- a_i  input  WIDTH  operand A
- b_i  input  WIDTH  operand B
- cin_i  input  1  carry-in, used in add mode only
- sub_i  input  1  0 = A+B+cin_i; 1 = A−B
- out_valid_o  output  1  result valid
- out_ready_i  input  1  downstream accepts the result
- s_o  output  WIDTH  sum/difference
- cout_o  output  1  carry-out. In sub mode: 1 = no borrow (A ≥ B unsigned).
- ovf_o  output  1  two's-complement signed overflow

Behaviour:
- Reset: out_valid_o=0, s_o=0, cout_o=0, ovf_o=0. All stage valid bits, partial sums, skew registers and carries cleared.
- Reset applied mid-operation flushes in-flight transactions. None emerge after reset. in_ready_o=1 during and after reset.
- Effective operation:
  - B' = sub_i ? ~b_i : b_i
  - c0 = sub_i ? 1 : cin_i
  - result = A + B' + c0, computed modulo 2^WIDTH.
- Stage k (0..NSEG−1) adds segment k of A and B' plus the carry registered from stage k−1 (stage 0 uses c0).
- Upper, not-yet-added segments travel in input-skew registers. Completed lower segments travel in output-deskew registers. All segments of one transaction emerge together.
- cout_o = carry out of the MSB. ovf_o = carry into the MSB XOR carry out of the MSB.
- Latency: NSEG cycles from the accepting edge (in_valid_i & in_ready_o) to out_valid_o=1. With NSEG=1 the latency is 1 cycle and there is no inter-stage carry.
- Pipeline enable: en = ~out_valid_o | out_ready_i. in_ready_o = en.
- Stall behaviour:
  - When en=0, every stage holds, including bubbles.
  - s_o/cout_o/ovf_o/out_valid_o stay stable while out_valid_o=1 and out_ready_i=0.
- Bubbles: in_valid_i=0 with en=1 inserts a bubble. Bubbles advance and never produce out_valid_o=1.
- Simultaneous events: accepting a new input and handing off an output in the same cycle is allowed and required for full throughput. Nothing is dropped or duplicated.
- Ordering: results emerge strictly in acceptance order.
- Inputs sampled while in_ready_o=0 are ignored. The source must hold them (standard valid/ready).
- Data registers of invalid stages may hold stale values. s_o is meaningful only when out_valid_o=1.
- No combinational path from a_i/b_i to s_o. out_ready_i → in_ready_o is the only combinational path.

Test Plan (WIDTH=64, SEG_WIDTH=16, latency 4):
1. Full carry chain across all segment boundaries. Add a=FFFF_FFFF_FFFF_FFFF, b=1, cin=0 → exactly 4 cycles after accept: s_o=0, cout_o=1, ovf_o=0. Also a=0000_0000_0000_FFFF, b=1 → s_o=0000_0000_0001_0000, cout_o=0.
2. Subtract. sub=1, a=5, b=7 → s_o=FFFF_FFFF_FFFF_FFFE, cout_o=0, ovf_o=0. Also a=7, b=5 → s_o=2, cout_o=1.
3. Signed overflow.
   - Add a=7FFF_FFFF_FFFF_FFFF, b=1 → s_o=8000_0000_0000_0000, ovf_o=1, cout_o=0.
   - sub=1, a=8000_0000_0000_0000, b=1 → s_o=7FFF_FFFF_FFFF_FFFF, ovf_o=1.
   - cin_i=1 is ignored in sub mode.
4. Throughput. 8 back-to-back transactions a=i, b=i·2^48, cin=i[0], out_ready_i=1 → 8 consecutive valid outputs starting cycle 4, in order, each s_o = a+b+cin.
5. Backpressure. With 3 transactions in flight, drop out_ready_i for 3 cycles → in_ready_o=0 for those cycles, s_o stable, no loss or duplication. All 3 results delivered in order after release.
6. Reset mid-flight. Accept 2 transactions, assert rst_i for 1 cycle on the next edge → out_valid_o=0 and s_o=0 next cycle. No result appears within the following 8 cycles. A new transaction afterwards completes with 4-cycle latency.
   - Repeat scenarios 1–4 with SEG_WIDTH=64 (latency 1) and SEG_WIDTH=8 (latency 8).
